// File: rtl/amber48_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | amber48_pkg : shared amber48 types and constants  (rev 1.0)        |
// +--------------------------------------------------------------------+
package amber48_pkg;

    localparam int XLEN        = 48;
    // Bytes per addressable data word: one full 48-bit machine word.
    localparam int BAU_BYTES   = 6;
    localparam int DMEM_WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WAIT    = 2'd2,
        RESP    = 2'd3
    } amber48_dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/amber48_dmem_range_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | amber48_dmem_range_check : SRAM window / alignment check (rev 1.0) |
// +--------------------------------------------------------------------+
module amber48_dmem_range_check
    import amber48_pkg::*;
#(
    parameter logic [XLEN-1:0] MEM_BASE  = 48'h0000_0000_1000,
    parameter int              MEM_WORDS = 4096,
    parameter int              AW        = $clog2(MEM_WORDS)
) (
    input  logic [XLEN-1:0] addr,
    output logic            fault,
    output logic [AW-1:0]   index
);

    localparam logic [XLEN-1:0] BAU   = XLEN'(BAU_BYTES);
    localparam logic [XLEN-1:0] LIMIT = XLEN'(MEM_WORDS * BAU_BYTES);

    logic [XLEN-1:0] off;
    logic            below;
    logic            beyond;
    logic            misaligned;

    // Offset wraps on underflow; the explicit below-base term catches that case.
    assign off        = addr - MEM_BASE;
    assign below      = addr < MEM_BASE;
    assign beyond     = off >= LIMIT;
    assign misaligned = (off % BAU) != '0;
    assign fault      = below || beyond || misaligned;
    assign index      = AW'(off / BAU);

endmodule
`default_nettype wire

// File: rtl/amber48_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | amber48_dmem_ctrl : core dmem port to 1-cycle sync SRAM  (rev 1.0) |
// +--------------------------------------------------------------------+
module amber48_dmem_ctrl
    import amber48_pkg::*;
#(
    parameter logic [XLEN-1:0] MEM_BASE    = 48'h0000_0000_1000,
    parameter int              MEM_WORDS   = 4096,
    parameter int              WAIT_STATES = 0,
    parameter int              AW          = $clog2(MEM_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clk_en_i,
    input  logic            dmem_req_i,
    input  logic            dmem_we_i,
    input  logic [XLEN-1:0] dmem_addr_i,
    input  logic [XLEN-1:0] dmem_wdata_i,
    output logic [XLEN-1:0] dmem_rdata_o,
    output logic            dmem_ready_o,
    output logic            dmem_trap_o,
    output logic            sram_en_o,
    output logic            sram_we_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [XLEN-1:0] sram_wdata_o,
    input  logic [XLEN-1:0] sram_rdata_i,
    output logic [XLEN-1:0] fault_addr_o,
    output logic            busy_o
);

    localparam logic [DMEM_WAIT_W-1:0] WAIT_LAST =
        DMEM_WAIT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    amber48_dmem_state_e    state_q;
    amber48_dmem_state_e    state_d;
    logic [DMEM_WAIT_W-1:0] wait_cnt_q;
    logic [XLEN-1:0]        rdata_q;
    logic [XLEN-1:0]        fault_addr_q;
    logic                   trap_q;
    logic                   we_q;
    logic                   fault;
    logic [AW-1:0]          word_idx;
    logic                   accept;

    amber48_dmem_range_check #(
        .MEM_BASE  (MEM_BASE),
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_range_check (
        .addr  (dmem_addr_i),
        .fault (fault),
        .index (word_idx)
    );

    assign accept = (state_q == IDLE) && dmem_req_i && clk_en_i;

    always_comb begin
        state_d      = state_q;
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_d = RESP;
                    end else begin
                        sram_en_o    = 1'b1;
                        sram_we_o    = dmem_we_i;
                        sram_addr_o  = word_idx;
                        sram_wdata_o = dmem_wdata_i;
                        state_d      = CAPTURE;
                    end
                end
            end
            CAPTURE: state_d = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt_q == WAIT_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            rdata_q      <= '0;
            fault_addr_q <= '0;
            trap_q       <= 1'b0;
            we_q         <= 1'b0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (dmem_req_i) begin
                        we_q   <= dmem_we_i;
                        trap_q <= fault;
                        // Faults skip CAPTURE, so stale load data must be cleared here.
                        if (fault) begin
                            fault_addr_q <= dmem_addr_i;
                            rdata_q      <= '0;
                        end
                    end
                end
                CAPTURE: begin
                    rdata_q    <= we_q ? '0 : sram_rdata_i;
                    wait_cnt_q <= '0;
                end
                WAIT:    wait_cnt_q <= wait_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign dmem_ready_o = (state_q == RESP);
    assign dmem_trap_o  = dmem_ready_o && trap_q;
    assign dmem_rdata_o = dmem_ready_o ? rdata_q : '0;
    assign fault_addr_o = fault_addr_q;
    assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_amber48_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_amber48_dmem_ctrl : directed bench for amber48_dmem_ctrl (rev 1.0)|
// +--------------------------------------------------------------------+
module tb_amber48_dmem_ctrl;
    import amber48_pkg::*;

    localparam int              AW   = 4;
    localparam int              B    = BAU_BYTES;
    localparam logic [47:0]     BASE = 48'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        req = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic [47:0] addr = '0;
    logic [47:0] wdata = '0;

    logic [47:0] rdata, rdata3, sram_wdata, sram_wdata3, sram_rdata, sram_rdata3;
    logic [47:0] fault_addr, fault_addr3;
    logic        ready, ready3, trap, trap3, sram_en, sram_en3, sram_we, sram_we3;
    logic        busy, busy3;
    logic [AW-1:0] sram_addr, sram_addr3;

    logic [47:0] mem0 [16];
    logic [47:0] mem3 [16];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    amber48_dmem_ctrl #(.MEM_BASE(BASE), .MEM_WORDS(16), .WAIT_STATES(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en),
        .dmem_req_i(req), .dmem_we_i(we), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
        .dmem_rdata_o(rdata), .dmem_ready_o(ready), .dmem_trap_o(trap),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .fault_addr_o(fault_addr), .busy_o(busy)
    );

    amber48_dmem_ctrl #(.MEM_BASE(BASE), .MEM_WORDS(16), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en),
        .dmem_req_i(req3), .dmem_we_i(we), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
        .dmem_rdata_o(rdata3), .dmem_ready_o(ready3), .dmem_trap_o(trap3),
        .sram_en_o(sram_en3), .sram_we_o(sram_we3), .sram_addr_o(sram_addr3),
        .sram_wdata_o(sram_wdata3), .sram_rdata_i(sram_rdata3),
        .fault_addr_o(fault_addr3), .busy_o(busy3)
    );

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 48'h0A0A_0000_0000 + 48'(i);
            mem3[i] = 48'h0A0A_0000_0000 + 48'(i);
        end
        sram_rdata  = '0;
        sram_rdata3 = '0;
    end

    // Single-port synchronous SRAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem0[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem0[sram_addr];
        end
        if (sram_en3) begin
            if (sram_we3) mem3[sram_addr3] <= sram_wdata3;
            else          sram_rdata3 <= mem3[sram_addr3];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request on dut and holds it until ready (bounded), returning what was seen.
    task automatic xact(input logic w, input logic [47:0] a, input logic [47:0] d,
                        output int lat, output logic [47:0] rd, output logic tr,
                        output logic acc_en, output logic acc_we,
                        output logic [AW-1:0] acc_addr, output int extra_en);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        #1;
        acc_en = sram_en; acc_we = sram_we; acc_addr = sram_addr;
        extra_en = 0; lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
            extra_en += int'(sram_en);
        end while (!ready && lat < 30);
        rd = rdata; tr = trap;
        req = 1'b0;
    endtask

    int            lat, extra, cnt, busy_cnt, pulses;
    logic [47:0]   rd;
    logic          tr, a_en, a_we;
    logic [AW-1:0] a_addr;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_ready", ready, 0);
        chk("rst_trap", trap, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_fault_addr", fault_addr, 0);
        chk("rst_busy", busy, 0);

        // Scenario 1: store then load word 3
        xact(1'b1, BASE + 48'(3*B), 48'h0000_DEAD_BEEF, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("st_acc_en", a_en, 1);
        chk("st_acc_we", a_we, 1);
        chk("st_acc_addr", a_addr, 3);
        chk("st_lat", lat, 2);
        chk("st_trap", tr, 0);
        chk("st_rdata", rd, 0);
        chk("st_extra_en", extra, 0);
        xact(1'b0, BASE + 48'(3*B), 48'h0, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("ld_acc_en", a_en, 1);
        chk("ld_acc_we", a_we, 0);
        chk("ld_lat", lat, 2);
        chk("ld_rdata", rd, 48'h0000_DEAD_BEEF);
        chk("ld_trap", tr, 0);
        #5;
        chk("ld_rdata_after", rdata, 0);

        // Last valid word, store then load back
        xact(1'b1, BASE + 48'(15*B), 48'hFEED_0000_0015, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("w15_acc_addr", a_addr, 15);
        chk("w15_trap", tr, 0);
        xact(1'b0, BASE + 48'(15*B), 48'h0, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("w15_rdata", rd, 48'hFEED_0000_0015);

        // Scenario 2: one past the end, and below base
        xact(1'b0, BASE + 48'(16*B), 48'h0, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("end_acc_en", a_en, 0);
        chk("end_lat", lat, 1);
        chk("end_trap", tr, 1);
        chk("end_rdata", rd, 0);
        chk("end_extra_en", extra, 0);
        chk("end_fault_addr", fault_addr, BASE + 48'(16*B));
        xact(1'b0, 48'h0FFF, 48'h0, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("below_acc_en", a_en, 0);
        chk("below_lat", lat, 1);
        chk("below_trap", tr, 1);
        chk("below_rdata", rd, 0);
        chk("below_fault_addr", fault_addr, 48'h0FFF);

        // Scenario 3: misaligned (B = 6)
        xact(1'b0, 48'h1001, 48'h0, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("mis_acc_en", a_en, 0);
        chk("mis_lat", lat, 1);
        chk("mis_trap", tr, 1);
        chk("mis_fault_addr", fault_addr, 48'h1001);
        // A good access leaves fault_addr untouched
        xact(1'b0, BASE + 48'(3*B), 48'h0, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("fa_hold", fault_addr, 48'h1001);

        // Scenario 4: WAIT_STATES = 3, load word 5
        @(negedge clk);
        req3 = 1'b1; we = 1'b0; addr = BASE + 48'(5*B);
        #1;
        chk("ws_acc_en", sram_en3, 1);
        chk("ws_acc_addr", sram_addr3, 5);
        cnt = 0; busy_cnt = 0;
        do begin
            @(negedge clk); #1;
            cnt++;
            if (!ready3) busy_cnt += int'(busy3);
        end while (!ready3 && cnt < 30);
        chk("ws_lat", cnt, 5);
        chk("ws_busy_cycles", busy_cnt, 4);
        chk("ws_rdata", rdata3, 48'h0A0A_0000_0005);
        req3 = 1'b0;
        @(negedge clk); #1;
        chk("ws_busy_after", busy3, 0);

        // Scenario 5: clk_en gating
        @(negedge clk);
        clk_en = 1'b0; req = 1'b1; we = 1'b0; addr = BASE + 48'(3*B);
        #1;
        chk("ce_idle_no_en", sram_en, 0);
        @(negedge clk); #1;
        chk("ce_not_accepted", busy, 0);
        clk_en = 1'b1;
        #1;
        chk("ce_acc_en", sram_en, 1);
        @(negedge clk); #1;
        clk_en = 1'b0;
        cnt = 1; extra = 0;
        repeat (4) begin
            @(negedge clk); #1;
            cnt++;
            extra += int'(sram_en);
        end
        chk("ce_frozen_busy", busy, 1);
        chk("ce_frozen_ready", ready, 0);
        chk("ce_frozen_en", extra, 0);
        clk_en = 1'b1;
        do begin
            @(negedge clk); #1;
            cnt++;
        end while (!ready && cnt < 30);
        chk("ce_lat", cnt, 6);
        chk("ce_rdata", rdata, 48'h0000_DEAD_BEEF);
        req = 1'b0;

        // Scenario 6: reset in CAPTURE after a store strobe
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = BASE + 48'(7*B); wdata = 48'h1234_5678_9ABC;
        #1;
        chk("rs_acc_en", sram_en, 1);
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_ready", ready, 0);
        chk("rs_trap", trap, 0);
        chk("rs_rdata", rdata, 0);
        chk("rs_sram_en", sram_en, 0);
        chk("rs_fault_addr", fault_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk); #1;
            pulses += int'(ready);
        end
        chk("rs_no_ready", pulses, 0);
        xact(1'b0, BASE + 48'(7*B), 48'h0, lat, rd, tr, a_en, a_we, a_addr, extra);
        chk("rs_load_lat", lat, 2);
        chk("rs_load_rdata", rd, 48'h1234_5678_9ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/amber48_dmem_ctrl.md
Name: amber48_dmem_ctrl

Overview:
- Data-memory controller directly downstream of the amber48 core's execute-stage memory port.
- Accepts the core's dmem_req/we/addr/wdata, range- and alignment-checks the address, and drives a single-port synchronous SRAM with 1-cycle read latency.
- Returns a one-cycle ready pulse carrying either read data or a trap; the core stalls its pipeline until that pulse.

Parameters:
- MEM_BASE, 48'h0000_0000_1000: byte address of SRAM word 0.
- MEM_WORDS, 4096: SRAM depth in words; power of two, at least 2.
- WAIT_STATES, 0: extra cycles inserted before ready; 0..15.
- AW, $clog2(MEM_WORDS): SRAM address width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clk_en_i  in  1  global clock enable, same signal as the core's
- dmem_req_i  in  1  request; fields stable until ready
- dmem_we_i  in  1  1 = store, 0 = load
- dmem_addr_i  in  XLEN  byte address
- dmem_wdata_i  in  XLEN  store data
- dmem_rdata_o  out  XLEN  load data, valid while dmem_ready_o
- dmem_ready_o  out  1  transaction complete (1-cycle pulse)
- dmem_trap_o  out  1  access fault, qualified by dmem_ready_o
- sram_en_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write
- sram_addr_o  out  AW  SRAM word index
- sram_wdata_o  out  XLEN  SRAM write data
- sram_rdata_i  in  XLEN  SRAM read data, valid the cycle after en && !we
- fault_addr_o  out  XLEN  address of the most recent faulting request
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; wait counter, rdata_q and trap_q all 0.
- All state advances only on clock edges where clk_en_i = 1. When clk_en_i = 0, state and registered outputs hold, and sram_en_o = 0.
- Address check: off = dmem_addr_i - MEM_BASE, computed at XLEN width with unsigned wrap.
  - fault = (dmem_addr_i < MEM_BASE) || (off >= MEM_WORDS*BAU_BYTES) || (off % BAU_BYTES != 0).
  - Word index = off / BAU_BYTES, truncated to AW bits.
- IDLE state, when dmem_req_i && clk_en_i:
  - If fault: no SRAM access; trap_q <= 1; fault_addr_o <= dmem_addr_i; next state RESP. Fault-to-ready latency is 1 cycle.
  - Otherwise: in the same cycle, combinationally drive sram_en_o = 1, sram_we_o = dmem_we_i, sram_addr_o = index, sram_wdata_o = dmem_wdata_i. Latch we_q and set trap_q <= 0. Next state CAPTURE.
- CAPTURE: rdata_q <= we_q ? 0 : sram_rdata_i. Next state WAIT if WAIT_STATES > 0, otherwise RESP.
- WAIT: the counter runs 0..WAIT_STATES-1, then the FSM moves to RESP.
- RESP: dmem_ready_o = 1, dmem_trap_o = trap_q, dmem_rdata_o = rdata_q. The next state is unconditionally IDLE, so no request is accepted in the RESP cycle.
- dmem_rdata_o is 0 outside RESP, and is 0 on stores and faults.
- Latency from the accept cycle to the ready cycle: 2 + WAIT_STATES for valid accesses, 1 for faults.
- Accepted transactions always complete. A deassertion of dmem_req_i after accept is ignored, and the ready pulse is still emitted.
- sram_en_o is asserted exactly once per accepted non-faulting request. The SRAM is never accessed after a fault.
- Back-to-back requests: a request held high across RESP is accepted again in the following IDLE cycle. The core advances on ready, so this is a new request.
- Reset mid-transaction: return to IDLE with no ready pulse. An SRAM write already strobed remains committed.
- fault_addr_o holds until the next fault or reset.

Decomposition:
- amber48_pkg gains amber48_dmem_state_e (IDLE, CAPTURE, WAIT, RESP) and DMEM_WAIT_W = 4.
- XLEN and BAU_BYTES are reused from amber48_pkg.
- One combinational sub-module, amber48_dmem_range_check: inputs addr; outputs fault and word index; parameters MEM_BASE and MEM_WORDS.

Test Plan:
Common configuration for all scenarios: MEM_BASE = 48'h1000, MEM_WORDS = 16, B = BAU_BYTES, clk_en_i = 1 unless stated.
1. Store 48'h0000_DEAD_BEEF to 48'h1000+3*B, then load from the same address.
   - Store: sram_en/we with addr 3 in the accept cycle; ready 2 cycles later, trap 0.
   - Load: dmem_rdata_o = 48'h0000_DEAD_BEEF with ready.
2. Load from 48'h1000+16*B (one past the end) and from 48'h0FFF.
   - Each: ready 1 cycle after accept, trap 1, rdata 0, no sram_en.
   - fault_addr_o tracks each faulting address.
3. If B > 1, load from 48'h1001 -> misaligned trap 1, with fault timing as in scenario 2.
   - If B = 1, the same load reads word 1 with no trap.
4. WAIT_STATES = 3, load from word 5 -> ready exactly 5 cycles after accept; busy_o is high for 4 cycles.
5. Hold clk_en_i = 0 for 4 cycles while in CAPTURE -> state frozen and sram_en 0; ready arrives 4 cycles later than in scenario 1.
6. Reset pulse in CAPTURE, then drop req.
   - No ready pulse; all outputs 0.
   - A subsequent load returns the data that was written before the reset.
